// File: rtl/ours_vld_rdy_buf.sv
// Elastic valid/ready skid FIFO with optional same-cycle pass-through when empty.
// Define OURS_VLD_BUF_PERF_EN to add stall_cnt / hwm performance outputs.
module ours_vld_rdy_buf #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned PASSTHRU = 0,
  parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
`ifdef OURS_VLD_BUF_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [CNT_W-1:0]  hwm
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit PASS = (PASSTHRU != 0);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty, full, bypass, push, pop;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // in_ready looks only at stored state, never at out_ready.
  assign in_ready  = ~rst & ~flush & ~full;
  assign out_valid = ~rst & (~empty | (PASS & in_valid & ~flush));
  assign bypass    = PASS & empty & in_valid & out_ready & ~flush;
  assign push      = in_valid & in_ready & ~bypass;
  assign pop       = out_valid & out_ready & ~bypass & ~flush;
  assign out_data  = empty ? in_data : mem[rd_ptr_q];
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = inc_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = inc_ptr(rd_ptr_q);
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; entries are only read once counted.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

`ifdef OURS_VLD_BUF_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      hwm       <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (count_d > hwm) hwm <= count_d;
    end
  end
`endif

endmodule

// File: tb/tb_ours_vld_rdy_buf.sv
// Bench for ours_vld_rdy_buf: three configurations share one stimulus and are checked
// every cycle against a queue model, plus directed literal expectations.
module tb_ours_vld_rdy_buf;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, out_ready;
  logic [7:0] in_data;
  logic       ir  [3];
  logic       ov  [3];
  logic [7:0] od  [3];
  logic [1:0] cnt [3];
`ifdef OURS_VLD_BUF_PERF_EN
  logic [31:0] stl [3];
  logic [1:0]  hw  [3];
`endif

  localparam int unsigned DEP [3] = '{2, 3, 2};
  localparam bit          PT  [3] = '{1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  ours_vld_rdy_buf #(.DATA_W(8), .DEPTH(2), .PASSTHRU(0)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .count(cnt[0])
`ifdef OURS_VLD_BUF_PERF_EN
    , .stall_cnt(stl[0]), .hwm(hw[0])
`endif
  );

  ours_vld_rdy_buf #(.DATA_W(8), .DEPTH(3), .PASSTHRU(0)) u_d3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .count(cnt[1])
`ifdef OURS_VLD_BUF_PERF_EN
    , .stall_cnt(stl[1]), .hwm(hw[1])
`endif
  );

  ours_vld_rdy_buf #(.DATA_W(8), .DEPTH(2), .PASSTHRU(1)) u_pt (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .count(cnt[2])
`ifdef OURS_VLD_BUF_PERF_EN
    , .stall_cnt(stl[2]), .hwm(hw[2])
`endif
  );

  // Model: contents of each buffer as a queue, oldest first.
  logic [7:0]  mq [3][$];
  int unsigned m_stall [3];
  int unsigned m_hwm   [3];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[inst %0d] got %0h want %0h at %0t", name, i, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model at the negative edge.
  task automatic sample();
    int unsigned n;
    logic        e_ir, e_ov;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mq[i].delete();
        m_stall[i] = 0;
        m_hwm[i]   = 0;
      end
      n    = mq[i].size();
      e_ir = !rst && !flush && (n < DEP[i]);
      e_ov = !rst && ((n > 0) || (PT[i] && in_valid && !flush));
      chk("in_ready", i, 32'(ir[i]), 32'(e_ir));
      chk("out_valid", i, 32'(ov[i]), 32'(e_ov));
      chk("count", i, 32'(cnt[i]), n);
      if (e_ov) chk("out_data", i, 32'(od[i]), 32'((n > 0) ? mq[i][0] : in_data));
`ifdef OURS_VLD_BUF_PERF_EN
      chk("stall_cnt", i, stl[i], m_stall[i]);
      chk("hwm", i, 32'(hw[i]), m_hwm[i]);
`endif
    end
  endtask

  // Apply the transfer rules for the coming rising edge, then move past it.
  task automatic adv();
    int unsigned n;
    logic        vis, byp, acc, deq;
    for (int i = 0; i < 3; i++) begin
      n   = mq[i].size();
      vis = !rst && ((n > 0) || (PT[i] && in_valid && !flush));
      if (vis && !out_ready && m_stall[i] != 32'hFFFF_FFFF) m_stall[i]++;
      if (!rst) begin
        if (flush) begin
          mq[i].delete();
        end else begin
          byp = PT[i] && (n == 0) && in_valid && out_ready;
          acc = in_valid && (n < DEP[i]) && !byp;
          deq = (n > 0) && out_ready;
          if (deq) void'(mq[i].pop_front());
          if (acc) mq[i].push_back(in_data);
        end
        if (mq[i].size() > m_hwm[i]) m_hwm[i] = mq[i].size();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int k);
    for (int j = 0; j < k; j++) begin
      sample();
      adv();
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    sample();
    chk("rst_in_ready", 0, 32'(ir[0]), 32'd0);
    chk("rst_out_valid", 2, 32'(ov[2]), 32'd0);
    chk("rst_count", 1, 32'(cnt[1]), 32'd0);
    adv();
    cyc(1);
    rst = 1'b0;

    // Fill depth-2 buffer while downstream stalls, then drain in order.
    in_valid = 1'b1; in_data = 8'hA1;
    cyc(1);
    in_data = 8'hB2;
    cyc(1);
    in_valid = 1'b0;
    sample();
    chk("fill_count", 0, 32'(cnt[0]), 32'd2);
    chk("fill_in_ready", 0, 32'(ir[0]), 32'd0);
    adv();
    out_ready = 1'b1;
    sample();
    chk("drain_first", 0, 32'(od[0]), 32'hA1);
    adv();
    sample();
    chk("drain_second", 0, 32'(od[0]), 32'hB2);
    adv();
    sample();
    chk("drain_empty", 0, 32'(ov[0]), 32'd0);
    adv();

    // Pass-through while empty.
    in_valid = 1'b1; in_data = 8'h55;
    sample();
    chk("pt_out_valid", 2, 32'(ov[2]), 32'd1);
    chk("pt_out_data", 2, 32'(od[2]), 32'h55);
    chk("pt_count", 2, 32'(cnt[2]), 32'd0);
    chk("nopt_out_valid", 0, 32'(ov[0]), 32'd0);
    adv();
    in_valid = 1'b0;
    cyc(2);

    // Streaming 0..99: one-cycle latency, occupancy steady at one.
    in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      in_data = 8'(k);
      sample();
      if (k > 0) begin
        chk("stream_data", 1, 32'(od[1]), 32'(k - 1));
        chk("stream_count", 1, 32'(cnt[1]), 32'd1);
      end
      adv();
    end
    in_valid = 1'b0;
    cyc(2);

    // Full depth-3: a pop in the full cycle must not raise in_ready yet.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'(8'h10 + k);
      cyc(1);
    end
    in_data = 8'h13; out_ready = 1'b1;
    sample();
    chk("full_count", 1, 32'(cnt[1]), 32'd3);
    chk("full_in_ready", 1, 32'(ir[1]), 32'd0);
    adv();
    out_ready = 1'b0;
    sample();
    chk("after_pop_count", 1, 32'(cnt[1]), 32'd2);
    chk("after_pop_in_ready", 1, 32'(ir[1]), 32'd1);
    adv();
    in_valid = 1'b0; out_ready = 1'b1;
    cyc(4);

    // Flush beats a concurrent push.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h20;
    cyc(1);
    in_data = 8'h21;
    cyc(1);
    flush = 1'b1; in_data = 8'h22;
    sample();
    chk("flush_in_ready", 0, 32'(ir[0]), 32'd0);
    chk("flush_out_valid", 0, 32'(ov[0]), 32'd1);
    adv();
    flush = 1'b0; in_valid = 1'b0;
    sample();
    chk("post_flush_count", 0, 32'(cnt[0]), 32'd0);
    chk("post_flush_valid", 0, 32'(ov[0]), 32'd0);
    chk("post_flush_count3", 1, 32'(cnt[1]), 32'd0);
    adv();
    out_ready = 1'b1;
    cyc(2);

    // Asynchronous reset mid-stream.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h30;
    cyc(1);
    in_data = 8'h31;
    cyc(1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    sample();
    chk("midrst_in_ready", 0, 32'(ir[0]), 32'd0);
    chk("midrst_out_valid", 0, 32'(ov[0]), 32'd0);
    chk("midrst_count", 0, 32'(cnt[0]), 32'd0);
    adv();
    rst = 1'b0;

    // Seven stall cycles after reset on the depth-2 buffer.
    in_valid = 1'b1; in_data = 8'h40;
    cyc(1);
    in_data = 8'h41;
    cyc(1);
    in_valid = 1'b0;
    cyc(6);
    sample();
    chk("stall_count_occ", 0, 32'(cnt[0]), 32'd2);
`ifdef OURS_VLD_BUF_PERF_EN
    chk("stall_cnt_lit", 0, stl[0], 32'd7);
    chk("hwm_lit", 0, 32'(hw[0]), 32'd2);
`endif
    adv();
    out_ready = 1'b1;
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
